// File: rtl/ref_mem_server.sv
// Memory-side responder for the reference-window fetch: prefetches 64-bit words in
// bursts into a small FIFO and hands them to the reference buffer in byte-offset order.
module ref_mem_server #(
  parameter int DEPTH       = 16,
  parameter int BURST       = 4,
  parameter int FRAME_BYTES = 307200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] frame_base,
  input  logic [31:0] ref_mem_addr,
  input  logic        ref_take,
  output logic [63:0] ref_in,
  output logic        ref_en,
  output logic        addr_err,
  output logic        frame_done,
  output logic        mem_rd_req,
  output logic [31:0] mem_rd_addr,
  input  logic        mem_rd_ready,
  input  logic [63:0] mem_rd_data,
  input  logic        mem_rd_dvalid
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(BURST + 1);
  localparam logic [31:0] BURST_BYTES = 32'(8 * BURST);
  localparam logic [31:0] FRAME_END   = 32'(FRAME_BYTES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [31:0]   frame_base_q, frame_base_d;
  logic [31:0]   fetch_off_q, fetch_off_d;
  logic [31:0]   exp_off_q, exp_off_d;
  logic [31:0]   resync_off_q, resync_off_d;
  logic [31:0]   mem_rd_addr_q, mem_rd_addr_d;
  logic          active_q, active_d;
  logic          pending_q, pending_d;
  logic          discard_q, discard_d;
  logic          addr_err_q, addr_err_d;
  logic          frame_done_q, frame_done_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] head_idx;
  logic [CW-1:0] count_q, count_d, count_after_pop;
  logic [OW-1:0] out_q, out_d;
  logic [63:0]   ref_in_q;
  logic [63:0]   fifo_mem [DEPTH];

  logic ref_en_w, take_ok, seq_ok, pop, mismatch, accept, beat, push;
  logic free_ok, fifo_clr, head_bypass, load_head;

  always_comb begin
    ref_en_w        = active_q & (count_q != '0) & ~pending_q;
    take_ok         = ref_take & ref_en_w & ~start;
    seq_ok          = (ref_mem_addr == exp_off_q);
    pop             = take_ok & seq_ok;
    mismatch        = take_ok & ~seq_ok;
    accept          = (state_q == S_REQ) & mem_rd_ready;
    beat            = (state_q == S_DATA) & mem_rd_dvalid & (out_q != '0);
    // Beats of a burst that was overtaken by a resync or a new start are dropped.
    push            = beat & ~pending_q & ~discard_q & ~start;
    free_ok         = (32'(count_q) + 32'(out_q) + 32'(BURST)) <= 32'(DEPTH);
    fifo_clr        = start | (state_q == S_FLUSH);
    count_after_pop = count_q - CW'(pop);
    head_idx        = rd_ptr_q + AW'(pop);
    head_bypass     = (count_after_pop == '0);
    load_head       = ~fifo_clr & (pop | (count_q == '0)) & (push | ~head_bypass);

    state_d       = state_q;
    frame_base_d  = frame_base_q;
    fetch_off_d   = fetch_off_q;
    exp_off_d     = exp_off_q;
    resync_off_d  = resync_off_q;
    mem_rd_addr_d = mem_rd_addr_q;
    active_d      = active_q;
    pending_d     = pending_q;
    discard_d     = discard_q;
    addr_err_d    = addr_err_q;
    frame_done_d  = 1'b0;
    out_d         = out_q;
    wr_ptr_d      = wr_ptr_q + AW'(push);
    rd_ptr_d      = head_idx;
    count_d       = count_after_pop + CW'(push);

    if (pop) begin
      exp_off_d = exp_off_q + 32'd8;
      if (exp_off_q + 32'd8 == FRAME_END) begin
        frame_done_d = 1'b1;
        active_d     = 1'b0;
      end
    end

    if (mismatch) begin
      addr_err_d   = 1'b1;
      resync_off_d = ref_mem_addr;
      pending_d    = 1'b1;
      if (ref_mem_addr >= FRAME_END) begin
        active_d = 1'b0;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (pending_q) begin
          state_d = S_FLUSH;
        end else if (active_q && free_ok && (fetch_off_q < FRAME_END)) begin
          state_d       = S_REQ;
          mem_rd_addr_d = frame_base_q + fetch_off_q;
        end
      end
      S_REQ: begin
        if (accept) begin
          fetch_off_d = fetch_off_q + BURST_BYTES;
          out_d       = OW'(BURST);
          state_d     = S_DATA;
        end
      end
      S_DATA: begin
        if (beat) begin
          out_d = out_q - OW'(1);
          if (out_q == OW'(1)) begin
            discard_d = 1'b0;
            state_d   = pending_q ? S_FLUSH : S_IDLE;
          end
        end
      end
      default: begin
        fetch_off_d = resync_off_q;
        exp_off_d   = resync_off_q;
        pending_d   = 1'b0;
        state_d     = S_IDLE;
      end
    endcase

    if (fifo_clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    // A new frame must wait out any burst still in flight before requesting again.
    if (start) begin
      frame_base_d = frame_base;
      active_d     = 1'b1;
      fetch_off_d  = '0;
      exp_off_d    = '0;
      addr_err_d   = 1'b0;
      pending_d    = 1'b0;
      frame_done_d = 1'b0;
      discard_d    = (out_d != '0);
      state_d      = (out_d != '0) ? S_DATA : S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      frame_base_q  <= '0;
      fetch_off_q   <= '0;
      exp_off_q     <= '0;
      resync_off_q  <= '0;
      mem_rd_addr_q <= '0;
      active_q      <= 1'b0;
      pending_q     <= 1'b0;
      discard_q     <= 1'b0;
      addr_err_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      out_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      ref_in_q      <= '0;
    end else begin
      state_q       <= state_d;
      frame_base_q  <= frame_base_d;
      fetch_off_q   <= fetch_off_d;
      exp_off_q     <= exp_off_d;
      resync_off_q  <= resync_off_d;
      mem_rd_addr_q <= mem_rd_addr_d;
      active_q      <= active_d;
      pending_q     <= pending_d;
      discard_q     <= discard_d;
      addr_err_q    <= addr_err_d;
      frame_done_q  <= frame_done_d;
      out_q         <= out_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      if (load_head) begin
        ref_in_q <= head_bypass ? mem_rd_data : fifo_mem[head_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= mem_rd_data;
    end
  end

  assign ref_in      = ref_in_q;
  assign ref_en      = ref_en_w;
  assign addr_err    = addr_err_q;
  assign frame_done  = frame_done_q;
  assign mem_rd_req  = (state_q == S_REQ);
  assign mem_rd_addr = mem_rd_addr_q;

endmodule

// File: tb/tb_ref_mem_server.sv
// Directed bench for ref_mem_server: a burst memory model with 2-cycle data latency
// and a consumer that takes words by byte offset.
module tb_ref_mem_server;

  localparam int FRAME = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] frame_base = '0;
  logic [31:0] ref_mem_addr = '0;
  logic        ref_take = 1'b0;
  logic [63:0] ref_in;
  logic        ref_en;
  logic        addr_err;
  logic        frame_done;
  logic        mem_rd_req;
  logic [31:0] mem_rd_addr;
  logic        mem_rd_ready = 1'b0;
  logic [63:0] mem_rd_data = '0;
  logic        mem_rd_dvalid = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] beat_addr_q[$];
  int          beat_due_q[$];
  logic [31:0] acc_q[$];

  always #5 clk = ~clk;

  ref_mem_server #(.DEPTH(16), .BURST(4), .FRAME_BYTES(FRAME)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frame_base(frame_base),
    .ref_mem_addr(ref_mem_addr), .ref_take(ref_take), .ref_in(ref_in), .ref_en(ref_en),
    .addr_err(addr_err), .frame_done(frame_done), .mem_rd_req(mem_rd_req),
    .mem_rd_addr(mem_rd_addr), .mem_rd_ready(mem_rd_ready), .mem_rd_data(mem_rd_data),
    .mem_rd_dvalid(mem_rd_dvalid)
  );

  function automatic logic [63:0] word(input logic [31:0] a);
    return {a ^ 32'h5A5A_0000, a};
  endfunction

  // Accepted request -> 4 beats, the first sampled two edges after acceptance.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (mem_rd_req && mem_rd_ready) begin
      acc_q.push_back(mem_rd_addr);
      for (int k = 0; k < 4; k++) begin
        beat_addr_q.push_back(mem_rd_addr + 32'(8 * k));
        beat_due_q.push_back(cyc + 1 + k);
      end
    end
  end

  always @(negedge clk) begin
    if (beat_due_q.size() > 0 && beat_due_q[0] <= cyc) begin
      mem_rd_dvalid = 1'b1;
      mem_rd_data   = word(beat_addr_q[0]);
      void'(beat_addr_q.pop_front());
      void'(beat_due_q.pop_front());
    end else begin
      mem_rd_dvalid = 1'b0;
      mem_rd_data   = '0;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] base);
    start = 1'b1;
    frame_base = base;
    step();
    start = 1'b0;
    acc_q.delete();
  endtask

  task automatic quiesce();
    ref_take = 1'b0;
    mem_rd_ready = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (beat_addr_q.size() == 0) break;
      step();
    end
  endtask

  task automatic take_word(input logic [31:0] off, output logic [63:0] w, output bit got);
    got = 1'b0;
    w = '0;
    for (int i = 0; i < 200; i++) begin
      if (ref_en) begin
        got = 1'b1;
        break;
      end
      step();
    end
    if (got) begin
      w = ref_in;
      ref_take = 1'b1;
      ref_mem_addr = off;
      step();
      ref_take = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    checks++; if (ref_en !== 1'b0) begin errors++; $display("FAIL rst_ref_en got=%b exp=0", ref_en); end
    checks++; if (mem_rd_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", mem_rd_req); end
    rst_n = 1'b1;
    repeat (2) step();
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL rst_addr_err got=%b exp=0", addr_err); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done got=%b exp=0", frame_done); end
    checks++; if (ref_in !== 64'd0) begin errors++; $display("FAIL rst_ref_in got=%h exp=0", ref_in); end
    checks++; if (mem_rd_addr !== 32'd0) begin errors++; $display("FAIL rst_rd_addr got=%h exp=0", mem_rd_addr); end
    checks++; if (mem_rd_req !== 1'b0) begin errors++; $display("FAIL idle_req got=%b exp=0", mem_rd_req); end
  endtask

  task automatic test_basic_stream();
    logic [63:0] w;
    bit got;
    mem_rd_ready = 1'b1;
    do_start(32'h1000);
    for (int i = 0; i < FRAME / 8; i++) begin
      take_word(32'(i * 8), w, got);
      checks++;
      if (!got || w !== word(32'h1000 + 32'(i * 8))) begin
        errors++; $display("FAIL basic_word[%0d] got=%h exp=%h", i, w, word(32'h1000 + 32'(i * 8)));
      end
      if (i == FRAME / 8 - 2) begin
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL basic_early_done got=%b exp=0", frame_done); end
      end
    end
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL basic_done got=%b exp=1", frame_done); end
    step();
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b exp=0", frame_done); end
    repeat (10) step();
    checks++; if (ref_en !== 1'b0) begin errors++; $display("FAIL basic_end_en got=%b exp=0", ref_en); end
    checks++; if (acc_q.size() != FRAME / 32) begin errors++; $display("FAIL basic_req_count got=%0d exp=%0d", acc_q.size(), FRAME / 32); end
    checks++; if (acc_q.size() < 2 || acc_q[0] !== 32'h1000) begin errors++; $display("FAIL basic_req0 got=%h exp=1000", acc_q[0]); end
    checks++; if (acc_q.size() < 2 || acc_q[1] !== 32'h1020) begin errors++; $display("FAIL basic_req1 got=%h exp=1020", acc_q[1]); end
  endtask

  task automatic test_back_pressure();
    logic [63:0] w;
    logic [63:0] held;
    bit got;
    quiesce();
    do_start(32'h2000);
    mem_rd_ready = 1'b1;
    held = '0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (i == 50) held = ref_in;
    end
    checks++; if (acc_q.size() != 4) begin errors++; $display("FAIL bp_req_count got=%0d exp=4", acc_q.size()); end
    checks++; if (mem_rd_req !== 1'b0) begin errors++; $display("FAIL bp_req_stopped got=%b exp=0", mem_rd_req); end
    checks++; if (ref_en !== 1'b1) begin errors++; $display("FAIL bp_ref_en got=%b exp=1", ref_en); end
    checks++; if (held !== word(32'h2000)) begin errors++; $display("FAIL bp_held_mid got=%h exp=%h", held, word(32'h2000)); end
    checks++; if (ref_in !== word(32'h2000)) begin errors++; $display("FAIL bp_held_end got=%h exp=%h", ref_in, word(32'h2000)); end
    for (int i = 0; i < 24; i++) begin
      take_word(32'(i * 8), w, got);
      checks++;
      if (!got || w !== word(32'h2000 + 32'(i * 8))) begin
        errors++; $display("FAIL bp_word[%0d] got=%h exp=%h", i, w, word(32'h2000 + 32'(i * 8)));
      end
    end
  endtask

  task automatic test_mem_stall();
    logic [63:0] w;
    bit got;
    int n;
    quiesce();
    do_start(32'h3000);
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (mem_rd_req) begin got = 1'b1; break; end
      step();
    end
    checks++; if (!got) begin errors++; $display("FAIL stall_req_wait got=timeout exp=req"); end
    for (int i = 0; i < 50; i++) begin
      checks++; if (ref_en !== 1'b0) begin errors++; $display("FAIL stall_en[%0d] got=%b exp=0", i, ref_en); end
      checks++; if (mem_rd_addr !== 32'h3000 || mem_rd_req !== 1'b1) begin
        errors++; $display("FAIL stall_addr[%0d] got=%h/%b exp=3000/1", i, mem_rd_addr, mem_rd_req);
      end
      step();
    end
    mem_rd_ready = 1'b1;
    n = 0;
    while (!ref_en && n < 10) begin
      step();
      n++;
    end
    checks++; if (n > 3) begin errors++; $display("FAIL stall_resume_cycles got=%0d exp<=3", n); end
    checks++; if (ref_in !== word(32'h3000)) begin errors++; $display("FAIL stall_first got=%h exp=%h", ref_in, word(32'h3000)); end
    for (int i = 0; i < 6; i++) begin
      take_word(32'(i * 8), w, got);
      checks++;
      if (!got || w !== word(32'h3000 + 32'(i * 8))) begin
        errors++; $display("FAIL stall_word[%0d] got=%h exp=%h", i, w, word(32'h3000 + 32'(i * 8)));
      end
    end
  endtask

  task automatic test_resync();
    logic [63:0] w;
    bit got;
    quiesce();
    do_start(32'h4000);
    mem_rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      take_word(32'(i * 8), w, got);
      checks++;
      if (!got || w !== word(32'h4000 + 32'(i * 8))) begin
        errors++; $display("FAIL rs_word[%0d] got=%h exp=%h", i, w, word(32'h4000 + 32'(i * 8)));
      end
    end
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (ref_en && beat_addr_q.size() == 2) begin got = 1'b1; break; end
      step();
    end
    checks++; if (!got) begin errors++; $display("FAIL rs_setup got=timeout exp=2_beats_due"); end
    ref_take = 1'b1;
    ref_mem_addr = 32'h200;
    step();
    ref_take = 1'b0;
    acc_q.delete();
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL rs_addr_err got=%b exp=1", addr_err); end
    checks++; if (ref_en !== 1'b0) begin errors++; $display("FAIL rs_en_drop got=%b exp=0", ref_en); end
    for (int i = 0; i < 4; i++) begin
      take_word(32'h200 + 32'(i * 8), w, got);
      checks++;
      if (!got || w !== word(32'h4200 + 32'(i * 8))) begin
        errors++; $display("FAIL rs_word_after[%0d] got=%h exp=%h", i, w, word(32'h4200 + 32'(i * 8)));
      end
    end
    checks++; if (acc_q.size() < 1 || acc_q[0] !== 32'h4200) begin errors++; $display("FAIL rs_next_req got=%h exp=4200", acc_q[0]); end
  endtask

  task automatic test_reset_mid();
    bit got;
    quiesce();
    do_start(32'h5000);
    mem_rd_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (ref_en && beat_addr_q.size() > 0) begin got = 1'b1; break; end
      step();
    end
    checks++; if (!got) begin errors++; $display("FAIL rm_setup got=timeout exp=data_phase"); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (ref_en !== 1'b0) begin errors++; $display("FAIL rm_ref_en got=%b exp=0", ref_en); end
    checks++; if (ref_in !== 64'd0) begin errors++; $display("FAIL rm_ref_in got=%h exp=0", ref_in); end
    checks++; if (mem_rd_addr !== 32'd0) begin errors++; $display("FAIL rm_rd_addr got=%h exp=0", mem_rd_addr); end
    checks++; if (mem_rd_req !== 1'b0 || addr_err !== 1'b0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL rm_flags got=%b%b%b exp=000", mem_rd_req, addr_err, frame_done);
    end
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (beat_addr_q.size() == 0) break;
      step();
    end
    repeat (3) step();
    checks++; if (ref_en !== 1'b0) begin errors++; $display("FAIL rm_late_beats got=%b exp=0", ref_en); end
    checks++; if (mem_rd_req !== 1'b0) begin errors++; $display("FAIL rm_idle_req got=%b exp=0", mem_rd_req); end
  endtask

  task automatic test_start_stream();
    logic [63:0] w;
    bit got;
    mem_rd_ready = 1'b1;
    do_start(32'h6000);
    for (int i = 0; i < 4; i++) begin
      take_word(32'(i * 8), w, got);
      checks++;
      if (!got || w !== word(32'h6000 + 32'(i * 8))) begin
        errors++; $display("FAIL ss_word[%0d] got=%h exp=%h", i, w, word(32'h6000 + 32'(i * 8)));
      end
    end
    checks++; if (acc_q.size() < 1 || acc_q[0] !== 32'h6000) begin errors++; $display("FAIL ss_first_req got=%h exp=6000", acc_q[0]); end
    take_word(32'h28, w, got);
    checks++; if (!got || addr_err !== 1'b1) begin errors++; $display("FAIL ss_addr_err got=%b exp=1", addr_err); end
    for (int i = 0; i < 2; i++) begin
      take_word(32'h28 + 32'(i * 8), w, got);
      checks++;
      if (!got || w !== word(32'h6028 + 32'(i * 8))) begin
        errors++; $display("FAIL ss_skip_word[%0d] got=%h exp=%h", i, w, word(32'h6028 + 32'(i * 8)));
      end
    end
    do_start(32'h80000);
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL ss_err_clear got=%b exp=0", addr_err); end
    checks++; if (ref_en !== 1'b0) begin errors++; $display("FAIL ss_en_after_start got=%b exp=0", ref_en); end
    for (int i = 0; i < 4; i++) begin
      take_word(32'(i * 8), w, got);
      checks++;
      if (!got || w !== word(32'h80000 + 32'(i * 8))) begin
        errors++; $display("FAIL ss_new_word[%0d] got=%h exp=%h", i, w, word(32'h80000 + 32'(i * 8)));
      end
    end
    checks++; if (acc_q.size() < 1 || acc_q[0] !== 32'h80000) begin errors++; $display("FAIL ss_new_req got=%h exp=80000", acc_q[0]); end
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_back_pressure();
    test_mem_stall();
    test_resync();
    test_reset_mid();
    test_start_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
